// File: rtl/prio_int_pkg.sv
`default_nettype none
// =====================================================================
// prio_int_pkg : shared types, opcodes and helpers for prio_int_ctrl
// Rev 1.0
// =====================================================================
package prio_int_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } ack_state_e;

    // OCW opcodes carried on d_in[7:5]
    localparam logic [2:0] OCW_AROT_OFF  = 3'b000;
    localparam logic [2:0] OCW_NSEOI     = 3'b001;
    localparam logic [2:0] OCW_RDSEL     = 3'b010;
    localparam logic [2:0] OCW_SEOI      = 3'b011;
    localparam logic [2:0] OCW_AROT_ON   = 3'b100;
    localparam logic [2:0] OCW_ROT_NSEOI = 3'b101;
    localparam logic [2:0] OCW_AEOI_ON   = 3'b110;

    localparam int ICW1_SEL_BIT  = 4;
    localparam int ICW1_LTIM_BIT = 3;

    // Position of a channel in the rotating order; 0 is highest priority.
    function automatic logic [2:0] prio_rank(input logic [2:0] idx,
                                             input logic [2:0] ptr,
                                             input int         n_ch);
        int d;
        d = int'(idx) - int'(ptr);
        if (d < 0) d = d + n_ch;
        return 3'(d);
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input int         n_ch);
        return (int'(idx) + 1 >= n_ch) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_int_resolve.sv
`default_nettype none
// =====================================================================
// prio_int_resolve : combinational rotating-priority encoder
// Rev 1.0
// =====================================================================
module prio_int_resolve
    import prio_int_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int IDX_W = 3
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [IDX_W:0]    sum;

    // Rotate so that rot[0] is the channel at the pointer, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_CH-1:0];
        valid = |rot;
        sum   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) sum = {1'b0, ptr} + (IDX_W+1)'(k);
        end
        if (sum >= (IDX_W+1)'(N_CH)) sum = sum - (IDX_W+1)'(N_CH);
        idx = sum[IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/prio_int_ctrl.sv
`default_nettype none
// =====================================================================
// prio_int_ctrl : prioritized interrupt controller with rotating priority.
// Automatic EOI is available when PRIO_INT_CTRL_AEOI_EN is defined.
// Rev 1.0
// =====================================================================
module prio_int_ctrl
    import prio_int_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int IDX_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ncs,
    input  logic            nwr,
    input  logic            nrd,
    input  logic            a0,
    input  logic [7:0]      d_in,
    output logic [7:0]      d_out,
    output logic            d_oe,
    input  logic [N_CH-1:0] ir,
    input  logic            ninta,
    output logic            int_o
);

    localparam logic [1:0]      S_IDLE = ST_IDLE;
    localparam logic [1:0]      S_ACK1 = ST_ACK1;
    localparam logic [1:0]      S_ACK2 = ST_ACK2;
    localparam logic [N_CH-1:0] ONE    = {{(N_CH-1){1'b0}}, 1'b1};

    logic [N_CH-1:0]  irr, isr, imr, ir_q;
    logic [IDX_W-1:0] ptr, win;
    logic [4:0]       vbase;
    logic             ltim, arot, rd_sel, icw2_arm, nwr_q, ninta_q;
    logic [1:0]       state;

    logic             wr_stb, is_icw1, is_icw2, is_imr, is_ocw;
    logic [2:0]       op;
    logic             ack_fall, ack_rise, ack1_ent, ack2_end, aeoi_end;
    logic             nseoi, rot_eoi, seoi, int_nxt;
    logic             pend_vld, isr_vld;
    logic [IDX_W-1:0] pend_idx, isr_idx;
    logic [N_CH-1:0]  pend, isr_clr, isr_set, irr_clr, irr_set, irr_nxt, isr_nxt;

    assign wr_stb  = ~ncs & ~nwr & nwr_q;
    assign op      = d_in[7:5];
    assign is_icw1 = wr_stb & ~a0 & d_in[ICW1_SEL_BIT];
    assign is_ocw  = wr_stb & ~a0 & ~d_in[ICW1_SEL_BIT];
    assign is_icw2 = wr_stb & a0 & icw2_arm;
    assign is_imr  = wr_stb & a0 & ~icw2_arm;

    assign ack_fall = ninta_q & ~ninta;
    assign ack_rise = ~ninta_q & ninta;
    assign ack1_ent = (state == S_IDLE) & ack_fall & ~is_icw1;
    assign ack2_end = (state == S_ACK2) & ack_rise & ~is_icw1;

    assign pend = irr & ~imr;

    prio_int_resolve #(.N_CH(N_CH), .IDX_W(IDX_W)) u_pend_res (
        .req   (pend),
        .ptr   (ptr),
        .valid (pend_vld),
        .idx   (pend_idx)
    );

    prio_int_resolve #(.N_CH(N_CH), .IDX_W(IDX_W)) u_isr_res (
        .req   (isr),
        .ptr   (ptr),
        .valid (isr_vld),
        .idx   (isr_idx)
    );

`ifdef PRIO_INT_CTRL_AEOI_EN
    logic aeoi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                aeoi <= 1'b0;
        else if (is_ocw && (op == OCW_AEOI_ON))   aeoi <= 1'b1;
    end

    assign aeoi_end = aeoi & ack2_end;
`else
    assign aeoi_end = 1'b0;
`endif

    assign nseoi   = (is_ocw & ((op == OCW_NSEOI) | (op == OCW_ROT_NSEOI))) | aeoi_end;
    assign rot_eoi = (is_ocw & (op == OCW_ROT_NSEOI))
                   | (is_ocw & (op == OCW_NSEOI) & arot)
                   | (aeoi_end & arot);
    assign seoi    = is_ocw & (op == OCW_SEOI) & (int'(d_in[2:0]) < N_CH);

    always_comb begin
        isr_clr = '0;
        if (nseoi && isr_vld) isr_clr = isr_clr | (ONE << isr_idx);
        if (seoi)             isr_clr = isr_clr | (ONE << d_in[2:0]);
    end

    assign isr_set = (ack1_ent && pend_vld) ? (ONE << pend_idx) : '0;
    assign irr_clr = isr_set;
    assign irr_set = ir & ~ir_q;

    // Requests arriving in the same cycle as a clear are never lost.
    always_comb begin
        irr_nxt = is_icw1 ? '0 : (irr & ~irr_clr);
        irr_nxt = ltim ? ir : (irr_nxt | irr_set);
        isr_nxt = is_icw1 ? '0 : ((isr & ~isr_clr) | isr_set);
    end

    assign int_nxt = pend_vld & (~isr_vld |
                     (prio_rank(pend_idx, ptr, N_CH) < prio_rank(isr_idx, ptr, N_CH)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nwr_q   <= 1'b1;
            ninta_q <= 1'b1;
            ir_q    <= '0;
            irr     <= '0;
            isr     <= '0;
            int_o   <= 1'b0;
        end else begin
            nwr_q   <= nwr;
            ninta_q <= ninta;
            ir_q    <= ir;
            irr     <= irr_nxt;
            isr     <= isr_nxt;
            int_o   <= ack1_ent ? 1'b0 : int_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imr      <= '0;
            ptr      <= '0;
            ltim     <= 1'b0;
            vbase    <= '0;
            arot     <= 1'b0;
            rd_sel   <= 1'b0;
            icw2_arm <= 1'b0;
        end else begin
            if (is_icw1) begin
                ltim     <= d_in[ICW1_LTIM_BIT];
                imr      <= '0;
                ptr      <= '0;
                arot     <= 1'b0;
                icw2_arm <= 1'b1;
            end else begin
                if (rot_eoi && isr_vld) ptr <= next_idx(isr_idx, N_CH);
                if (is_ocw && (op == OCW_AROT_ON))  arot   <= 1'b1;
                if (is_ocw && (op == OCW_AROT_OFF)) arot   <= 1'b0;
                if (is_ocw && (op == OCW_RDSEL))    rd_sel <= d_in[0];
            end
            if (is_icw2) begin
                vbase    <= d_in[7:3];
                icw2_arm <= 1'b0;
            end
            if (is_imr) imr <= d_in[N_CH-1:0];
        end
    end

    // Acknowledge sequencer; the winner is frozen at the first ninta edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            win   <= '0;
        end else if (is_icw1) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (ack_fall) begin
                    state <= S_ACK1;
                    win   <= pend_vld ? pend_idx : IDX_W'(N_CH - 1);
                end
                S_ACK1: if (ack_fall) state <= S_ACK2;
                S_ACK2: if (ack_rise) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        d_out = '0;
        d_oe  = 1'b0;
        if (!reset) begin
            if ((state == S_ACK2) && !ninta) begin
                d_oe  = 1'b1;
                d_out = {vbase, win};
            end else if (!ncs && !nrd) begin
                d_oe  = 1'b1;
                d_out = a0 ? MAX_CH'(imr) : (rd_sel ? MAX_CH'(isr) : MAX_CH'(irr));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_int_ctrl.sv
`default_nettype none
// =====================================================================
// tb_prio_int_ctrl : scoreboard bench with a channel-level reference model
// Rev 1.0
// =====================================================================
module tb_prio_int_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset, ncs, nwr, nrd, a0, ninta;
    logic [7:0]   d_in, d_out;
    logic         d_oe, int_o;
    logic [N-1:0] ir;

    always #5 clk = ~clk;

    prio_int_ctrl #(.N_CH(N), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .ncs   (ncs),
        .nwr   (nwr),
        .nrd   (nrd),
        .a0    (a0),
        .d_in  (d_in),
        .d_out (d_out),
        .d_oe  (d_oe),
        .ir    (ir),
        .ninta (ninta),
        .int_o (int_o)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // Reference model: channel bit sets plus priority pointer.
    bit [N-1:0] m_irr, m_isr, m_imr;
    int         m_ptr;
    bit         m_arot, m_rdsel, m_icw2, m_aeoi;
    bit [7:0]   m_vbase;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_first(input bit [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int m_rank(input int c);
        return (c - m_ptr + N) % N;
    endfunction

    function automatic bit m_int();
        int w, top;
        w   = m_first(m_irr & ~m_imr);
        top = m_first(m_isr);
        if (w < 0)   return 1'b0;
        if (top < 0) return 1'b1;
        return m_rank(w) < m_rank(top);
    endfunction

    function automatic void m_nseoi(input bit rot);
        int top;
        top = m_first(m_isr);
        if (top >= 0) begin
            m_isr[top] = 1'b0;
            if (rot) m_ptr = (top + 1) % N;
        end
    endfunction

    function automatic void m_reset();
        m_irr = '0; m_isr = '0; m_imr = '0; m_ptr = 0;
        m_arot = 0; m_rdsel = 0; m_icw2 = 0; m_aeoi = 0; m_vbase = '0;
    endfunction

    function automatic void m_write(input bit addr, input bit [7:0] data);
        if (!addr && data[4]) begin
            m_irr = '0; m_isr = '0; m_imr = '0; m_ptr = 0; m_arot = 0; m_icw2 = 1;
        end else if (addr && m_icw2) begin
            m_vbase = data & 8'hF8;
            m_icw2  = 0;
        end else if (addr) begin
            m_imr = data[N-1:0];
        end else begin
            case (data[7:5])
                3'b001: m_nseoi(m_arot);
                3'b011: m_isr[data[2:0]] = 1'b0;
                3'b101: m_nseoi(1'b1);
                3'b100: m_arot = 1'b1;
                3'b000: m_arot = 1'b0;
                3'b010: m_rdsel = data[0];
`ifdef PRIO_INT_CTRL_AEOI_EN
                3'b110: m_aeoi = 1'b1;
`endif
                default: ;
            endcase
        end
    endfunction

    // Monitor: every new presentation on the data bus consumes one expectation.
    logic oe_prev = 1'b0;
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (d_oe && !oe_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got 0x%0h with nothing expected at %0t", d_out, $time);
            end else begin
                e = exp_q.pop_front();
                check("bus_data", d_out, e);
            end
        end
        oe_prev = d_oe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input bit addr, input bit [7:0] data);
        a0 = addr; d_in = data; ncs = 0; nwr = 0;
        step();
        nwr = 1; ncs = 1;
        step();
        m_write(addr, data);
    endtask

    task automatic cpu_read(input bit addr, input int override);
        bit [7:0] e;
        e = addr ? 8'(m_imr) : (m_rdsel ? 8'(m_isr) : 8'(m_irr));
        if (override >= 0) e = 8'(override);
        exp_q.push_back(e);
        a0 = addr; ncs = 0; nrd = 0;
        step();
        nrd = 1; ncs = 1;
        step();
    endtask

    task automatic pulse(input bit [N-1:0] mask);
        ir = mask;
        step(); step();
        ir = '0;
        step();
        m_irr = m_irr | mask;
    endtask

    task automatic do_ack(input int override);
        int w;
        bit [7:0] e;
        w = m_first(m_irr & ~m_imr);
        e = m_vbase | 8'((w < 0) ? N - 1 : w);
        if (override >= 0) e = 8'(override);
        exp_q.push_back(e);
        ninta = 0; step();
        ninta = 1; step();
        ninta = 0; step(); step();
        ninta = 1; step(); step();
        if (w >= 0) begin
            m_isr[w] = 1'b1;
            m_irr[w] = 1'b0;
        end
        if (m_aeoi) m_nseoi(m_arot);
    endtask

    task automatic check_int(input string name);
        check(name, 8'(int_o), 8'(m_int()));
    endtask

    task automatic init();
        cpu_write(0, 8'h10);
        cpu_write(1, 8'h40);
        cpu_write(1, 8'h00);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; ncs = 1; nwr = 1; nrd = 1; a0 = 1; ninta = 1; ir = '0; d_in = '0;
        m_reset();
        step();
        ncs = 0; nrd = 0;
        step();
        check("reset_d_oe", 8'(d_oe), 8'h0);
        check("reset_d_out", d_out, 8'h00);
        check("reset_int_o", 8'(int_o), 8'h0);
        ncs = 1; nrd = 1;
        step();
        reset = 0;
        step();
        cpu_read(1, 8'h00);
        cpu_read(0, 8'h00);

        // Single request served end to end.
        init();
        pulse(8'h08);
        check("int_after_ir3", 8'(int_o), 8'h1);
        do_ack(8'h43);
        cpu_write(0, 8'h41);
        cpu_read(0, 8'h08);
        cpu_write(0, 8'h40);
        cpu_read(0, 8'h00);
        cpu_write(0, 8'h20);

        // Fully nested: lower-priority request waits for EOI.
        pulse(8'h22);
        do_ack(8'h41);
        check("int_nested_block", 8'(int_o), 8'h0);
        cpu_write(0, 8'h20);
        check("int_after_eoi", 8'(int_o), 8'h1);
        do_ack(8'h45);
        cpu_write(0, 8'h20);

        // Masking.
        cpu_write(1, 8'h02);
        pulse(8'h02);
        check("int_masked", 8'(int_o), 8'h0);
        cpu_write(1, 8'h00);
        check("int_unmasked", 8'(int_o), 8'h1);
        do_ack(8'h41);
        cpu_write(0, 8'h20);

        // Auto-rotate moves the pointer past the serviced channel.
        cpu_write(0, 8'h80);
        pulse(8'h01);
        do_ack(8'h40);
        cpu_write(0, 8'h20);
        pulse(8'h03);
        do_ack(8'h41);
        check_int("int_rotated_nested");
        cpu_write(0, 8'h20);
        do_ack(8'h40);
        cpu_write(0, 8'h20);
        cpu_write(0, 8'h00);

        // Spurious acknowledge leaves ISR untouched.
        pulse(8'h04);
        do_ack(-1);
        do_ack(8'h47);
        cpu_write(0, 8'h41);
        cpu_read(0, 8'h04);
        cpu_write(0, 8'h20);

        // Reset between the two acknowledge pulses aborts the cycle.
        ninta = 0; step();
        ninta = 1; step();
        reset = 1; step();
        check("midack_reset_d_oe", 8'(d_oe), 8'h0);
        reset = 0; step();
        m_reset();
        ninta = 0; step(); step();
        check("midack_no_vector", 8'(d_oe), 8'h0);
        ninta = 1; step();
        init();
        check_int("int_after_reinit");

`ifdef PRIO_INT_CTRL_AEOI_EN
        cpu_write(0, 8'hC0);
        pulse(8'h04);
        do_ack(8'h42);
        cpu_write(0, 8'h41);
        cpu_read(0, 8'h00);
`endif

        // Randomized traffic against the model.
        for (int it = 0; it < 200; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: pulse(N'(1 << $urandom_range(0, N - 1)) | N'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : 0));
                3, 4:    do_ack(-1);
                5:       cpu_write(0, 8'h20);
                6:       cpu_write(0, 8'h60 | 8'($urandom_range(0, 7)));
                7: begin
                    case ($urandom_range(0, 2))
                        0:       cpu_write(0, 8'h80);
                        1:       cpu_write(0, 8'h00);
                        default: cpu_write(0, 8'hA0);
                    endcase
                end
                8:       cpu_write(1, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
                default: begin
                    case ($urandom_range(0, 2))
                        0:       cpu_read(1, -1);
                        1: begin cpu_write(0, 8'h40); cpu_read(0, -1); end
                        default: begin cpu_write(0, 8'h41); cpu_read(0, -1); end
                    endcase
                end
            endcase
            check_int("int_random");
        end

        step(); step();
        check("pending_outputs", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
